// File: rtl/register_fifo.sv
// Register-based FIFO queue holding up to DEPTH words in arrival order.
// It has count/full/empty status, sticky overflow/underflow flags and a synchronous flush.
module register_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              wr_ok;
  logic              rd_ok;

  // Handshake: a write is taken when wr_en is high and there is room, or when a read
  // frees a slot in the same cycle. A read is taken when rd_en is high and the queue
  // is not empty. rd_data updates one edge later, and rd_valid pulses with it.
  // A write into an empty queue never falls through to a read in the same cycle.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  assign count = cnt;
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  // The storage array has no reset. Only the pointers decide which words are valid.
  always_ff @(posedge clk) begin
    if (rst && !clear && wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_en && full && !rd_en) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_fifo.sv
// Randomised and directed bench for register_fifo.
// Every output is compared against a queue-based model of the FIFO rules.
module tb_register_fifo;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  int err_cnt = 0;
  int chk_cnt = 0;

  // reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rd_valid;
  logic              m_ovf;
  logic              m_unf;

  register_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(exp_q.size()));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    check("rd_data", 32'(rd_data), 32'(m_rd_data));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_update(input logic w, input logic [DATA_W-1:0] d,
                              input logic r, input logic c);
    bit was_full, was_empty, do_rd, do_wr;
    if (c) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd_valid = 1'b0;
    end else begin
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      do_rd = r && !was_empty;
      do_wr = w && (!was_full || r);
      m_rd_valid = do_rd;
      if (do_rd) m_rd_data = exp_q.pop_front();
      if (do_wr) exp_q.push_back(d);
      if (w && was_full && !r) m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
    end
  endtask

  task automatic step(input logic w, input logic [DATA_W-1:0] d,
                      input logic r, input logic c);
    wr_en = w; wr_data = d; rd_en = r; clear = c;
    @(posedge clk); #1;
    model_update(w, d, r, c);
    compare_all();
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    compare_all();
  endtask

  initial begin
    logic [DATA_W-1:0] held;

    // 1: reset state
    do_reset();

    // 2: fill, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i * 'h11), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("drain_data", 32'(rd_data), 32'(i * 'h11));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // 3: overflow drops word; simultaneous wr+rd when full
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'('h0A0 + i), 1'b0, 1'b0);
    step(1'b1, 10'h3FF, 1'b0, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    step(1'b1, 10'h0A5, 1'b1, 1'b0);
    check("full_wr_rd_count", 32'(count), 32'd4);
    check("full_wr_rd_data", 32'(rd_data), 32'h0A1);
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("post_ovf_data", 32'(rd_data), 32'('h0A0 + i));
    end

    // 4: underflow holds rd_data; wr+rd when empty is write-only
    step(1'b0, '0, 1'b1, 1'b0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_hold", 32'(rd_data), 32'h0A5);
    step(1'b1, 10'h077, 1'b1, 1'b0);
    check("empty_wr_rd_count", 32'(count), 32'd1);
    check("empty_wr_rd_valid", 32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // 5: pointer wrap with interleaved pairs
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DATA_W'('h100 + i), 1'b0, 1'b0);
      check("wrap_count", 32'(count <= 1), 32'd1);
      step(1'b0, '0, 1'b1, 1'b0);
      check("wrap_data", 32'(rd_data), 32'('h100 + i));
    end

    // 6: clear with wr_en pending discards contents
    for (int i = 0; i < 3; i++) step(1'b1, DATA_W'('h1C0 + i), 1'b0, 1'b0);
    held = rd_data;
    step(1'b1, 10'h2AA, 1'b0, 1'b1);
    check("clear_count", 32'(count), 32'd0);
    check("clear_flags", 32'({overflow, underflow}), 32'd0);
    check("clear_hold", 32'(rd_data), 32'(held));
    step(1'b1, 10'h155, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("clear_next", 32'(rd_data), 32'h155);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), DATA_W'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
